// File: rtl/cs_microsequencer.sv
// cs_microsequencer: control-section microsequencer.
// Each cycle it picks the control store address mux selection from the MIR COND
// field and the PSR flags. It loads the chosen next address into CSAR and
// presents CSAR+1 as CSAI. Microcode is frozen while a main-memory access is
// waiting for MemReady, and while an external halt request is held.
//
// Optional feature: define CS_MICROSEQUENCER_TIMEOUT_EN to add a WAIT-cycle
// counter. After TIMEOUT_CYCLES wait cycles with no MemReady, the sequencer
// enters a sticky ERROR state that only reset can clear.
//
// Ports:
//   CS_MICROSEQUENCER_CLOCK_50          clock, rising edge
//   CS_MICROSEQUENCER_RESET_InLow       async active-low reset
//   CS_MICROSEQUENCER_COND_InBUS        MIR COND field
//   CS_MICROSEQUENCER_RD_In/WR_In       MIR memory read / write
//   CS_MICROSEQUENCER_MemReady_In       memory done (valid while MemReq_Out=1)
//   CS_MICROSEQUENCER_Flags_InBUS       PSR {n,z,v,c}
//   CS_MICROSEQUENCER_IR13_In           IR bit 13
//   CS_MICROSEQUENCER_HaltReq_In        halt request (level)
//   CS_MICROSEQUENCER_NextAddr_InBUS    address mux output
//   CS_MICROSEQUENCER_selection_OutBUS  mux select: 00 CSAI, 01 MIR, 10 decode
//   CS_MICROSEQUENCER_CSAR_OutBUS       registered control store address
//   CS_MICROSEQUENCER_CSAI_OutBUS       CSAR+1
//   CS_MICROSEQUENCER_MemReq_Out        memory access in progress
//   CS_MICROSEQUENCER_Stall_Out         CSAR/MIR hold this cycle
//   CS_MICROSEQUENCER_Halted_Out        in HALT
//   CS_MICROSEQUENCER_Timeout_Out       sticky memory timeout
module cs_microsequencer #(
  parameter int unsigned ADDR_LENGTH      = 11,
  parameter int unsigned SELECTION_LENGTH = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                        CS_MICROSEQUENCER_CLOCK_50,
  input  logic                        CS_MICROSEQUENCER_RESET_InLow,
  input  logic [2:0]                  CS_MICROSEQUENCER_COND_InBUS,
  input  logic                        CS_MICROSEQUENCER_RD_In,
  input  logic                        CS_MICROSEQUENCER_WR_In,
  input  logic                        CS_MICROSEQUENCER_MemReady_In,
  input  logic [3:0]                  CS_MICROSEQUENCER_Flags_InBUS,
  input  logic                        CS_MICROSEQUENCER_IR13_In,
  input  logic                        CS_MICROSEQUENCER_HaltReq_In,
  input  logic [ADDR_LENGTH-1:0]      CS_MICROSEQUENCER_NextAddr_InBUS,
  output logic [SELECTION_LENGTH-1:0] CS_MICROSEQUENCER_selection_OutBUS,
  output logic [ADDR_LENGTH-1:0]      CS_MICROSEQUENCER_CSAR_OutBUS,
  output logic [ADDR_LENGTH-1:0]      CS_MICROSEQUENCER_CSAI_OutBUS,
  output logic                        CS_MICROSEQUENCER_MemReq_Out,
  output logic                        CS_MICROSEQUENCER_Stall_Out,
  output logic                        CS_MICROSEQUENCER_Halted_Out,
  output logic                        CS_MICROSEQUENCER_Timeout_Out
);

  localparam logic [SELECTION_LENGTH-1:0] SEL_CSAI = SELECTION_LENGTH'(0);
  localparam logic [SELECTION_LENGTH-1:0] SEL_MIR  = SELECTION_LENGTH'(1);
  localparam logic [SELECTION_LENGTH-1:0] SEL_DEC  = SELECTION_LENGTH'(2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
    ST_ERROR = 2'd3,
`endif
    ST_HALT  = 2'd2
  } state_t;

  logic                   clk, rst_n;
  state_t                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] csar_q;
  logic                   load;
  logic                   mem_op;

  assign clk    = CS_MICROSEQUENCER_CLOCK_50;
  assign rst_n  = CS_MICROSEQUENCER_RESET_InLow;
  // RD and WR together still form a single access.
  assign mem_op = CS_MICROSEQUENCER_RD_In | CS_MICROSEQUENCER_WR_In;

  // Branch condition decode: flags are {n,z,v,c} with n in bit 3.
  always_comb begin
    CS_MICROSEQUENCER_selection_OutBUS = SEL_CSAI;
    case (CS_MICROSEQUENCER_COND_InBUS)
      3'b001: if (CS_MICROSEQUENCER_Flags_InBUS[3]) CS_MICROSEQUENCER_selection_OutBUS = SEL_MIR;
      3'b010: if (CS_MICROSEQUENCER_Flags_InBUS[2]) CS_MICROSEQUENCER_selection_OutBUS = SEL_MIR;
      3'b011: if (CS_MICROSEQUENCER_Flags_InBUS[1]) CS_MICROSEQUENCER_selection_OutBUS = SEL_MIR;
      3'b100: if (CS_MICROSEQUENCER_Flags_InBUS[0]) CS_MICROSEQUENCER_selection_OutBUS = SEL_MIR;
      3'b101: if (CS_MICROSEQUENCER_IR13_In)        CS_MICROSEQUENCER_selection_OutBUS = SEL_MIR;
      3'b110: CS_MICROSEQUENCER_selection_OutBUS = SEL_MIR;
      3'b111: CS_MICROSEQUENCER_selection_OutBUS = SEL_DEC;
      default: CS_MICROSEQUENCER_selection_OutBUS = SEL_CSAI;
    endcase
  end

`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // State, CSAR and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      csar_q  <= '0;
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) csar_q <= CS_MICROSEQUENCER_NextAddr_InBUS;
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | (state_d == ST_ERROR);
`endif
    end
  end

  // Next state, CSAR load enable and handshake outputs.
  always_comb begin
    state_d                      = state_q;
    load                         = 1'b0;
    CS_MICROSEQUENCER_MemReq_Out = 1'b0;
    CS_MICROSEQUENCER_Stall_Out  = 1'b0;
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
        // A memory op outranks a same-cycle halt request.
        if (mem_op) begin
          CS_MICROSEQUENCER_MemReq_Out = 1'b1;
          if (CS_MICROSEQUENCER_MemReady_In) begin
            load = 1'b1;
          end else begin
            CS_MICROSEQUENCER_Stall_Out = 1'b1;
            state_d = ST_WAIT;
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end else if (CS_MICROSEQUENCER_HaltReq_In) begin
          CS_MICROSEQUENCER_Stall_Out = 1'b1;
          state_d = ST_HALT;
        end else begin
          load = 1'b1;
        end
      end
      ST_WAIT: begin
        CS_MICROSEQUENCER_MemReq_Out = 1'b1;
        if (CS_MICROSEQUENCER_MemReady_In) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          CS_MICROSEQUENCER_Stall_Out = 1'b1;
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
          if (wait_cnt_q == CNT_LAST) state_d = ST_ERROR;
          else wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end
      ST_HALT: begin
        // Release returns to RUN without loading CSAR on that edge.
        CS_MICROSEQUENCER_Stall_Out = 1'b1;
        if (!CS_MICROSEQUENCER_HaltReq_In) state_d = ST_RUN;
      end
      default: begin
        // ERROR is left only through reset.
        CS_MICROSEQUENCER_Stall_Out = 1'b1;
      end
    endcase
  end

  assign CS_MICROSEQUENCER_CSAR_OutBUS = csar_q;
  assign CS_MICROSEQUENCER_CSAI_OutBUS = csar_q + ADDR_LENGTH'(1);
  assign CS_MICROSEQUENCER_Halted_Out  = (state_q == ST_HALT);
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
  assign CS_MICROSEQUENCER_Timeout_Out = timeout_q;
`else
  assign CS_MICROSEQUENCER_Timeout_Out = 1'b0;
`endif

endmodule

// File: tb/tb_cs_microsequencer.sv
// Testbench for cs_microsequencer: directed steps followed by random cycles,
// all checked against a behavioural model of the sequencer's rules.
module tb_cs_microsequencer;

  localparam int unsigned AW = 11;
  localparam int unsigned SW = 2;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    cond = '0;
  logic          rd = 1'b0, wr = 1'b0, ready = 1'b0;
  logic [3:0]    flags = '0;
  logic          ir13 = 1'b0, halt = 1'b0;
  logic [AW-1:0] next_addr = '0;
  logic [SW-1:0] sel;
  logic [AW-1:0] csar, csai;
  logic          memreq, stall, halted, timeout;

  always #5 clk = ~clk;

  cs_microsequencer #(.ADDR_LENGTH(AW), .SELECTION_LENGTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .CS_MICROSEQUENCER_CLOCK_50        (clk),
    .CS_MICROSEQUENCER_RESET_InLow     (rst_n),
    .CS_MICROSEQUENCER_COND_InBUS      (cond),
    .CS_MICROSEQUENCER_RD_In           (rd),
    .CS_MICROSEQUENCER_WR_In           (wr),
    .CS_MICROSEQUENCER_MemReady_In     (ready),
    .CS_MICROSEQUENCER_Flags_InBUS     (flags),
    .CS_MICROSEQUENCER_IR13_In         (ir13),
    .CS_MICROSEQUENCER_HaltReq_In      (halt),
    .CS_MICROSEQUENCER_NextAddr_InBUS  (next_addr),
    .CS_MICROSEQUENCER_selection_OutBUS(sel),
    .CS_MICROSEQUENCER_CSAR_OutBUS     (csar),
    .CS_MICROSEQUENCER_CSAI_OutBUS     (csai),
    .CS_MICROSEQUENCER_MemReq_Out      (memreq),
    .CS_MICROSEQUENCER_Stall_Out       (stall),
    .CS_MICROSEQUENCER_Halted_Out      (halted),
    .CS_MICROSEQUENCER_Timeout_Out     (timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: current address plus "waiting", "halted", "errored" flags.
  int unsigned exp_csar;
  bit          m_wait, m_halt, m_err;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [2:0] c, input logic [3:0] f, input logic ir);
    case (c)
      3'd0: return 2'd0;
      3'd1: return f[3] ? 2'd1 : 2'd0;
      3'd2: return f[2] ? 2'd1 : 2'd0;
      3'd3: return f[1] ? 2'd1 : 2'd0;
      3'd4: return f[0] ? 2'd1 : 2'd0;
      3'd5: return ir ? 2'd1 : 2'd0;
      3'd6: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // One clock: check mid-cycle outputs, advance model at the edge, check registers.
  task automatic step();
    bit mem, loads, mreq;
    #2;
    mem  = rd | wr;
    mreq = !m_err && !m_halt && (m_wait || mem);
    if (m_err || m_halt)    loads = 1'b0;
    else if (m_wait || mem) loads = ready;
    else                    loads = !halt;
    check("selection", 32'(sel), 32'(ref_sel(cond, flags, ir13)));
    check("memreq", 32'(memreq), 32'(mreq));
    check("stall", 32'(stall), 32'(!loads));
    check("csai", 32'(csai), (exp_csar + 1) % (1 << AW));
    @(posedge clk);
    if (loads) exp_csar = 32'(next_addr);
    if (m_err) begin
    end else if (m_halt) begin
      if (!halt) m_halt = 1'b0;
    end else if (m_wait) begin
      if (ready) m_wait = 1'b0;
      else begin
`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
        if (m_cnt == TO - 1) begin
          m_err = 1'b1;
          m_wait = 1'b0;
        end
`endif
        m_cnt++;
      end
    end else if (mem) begin
      if (!ready) begin
        m_wait = 1'b1;
        m_cnt  = 0;
      end
    end else if (halt) begin
      m_halt = 1'b1;
    end
    #1;
    check("csar", 32'(csar), exp_csar);
    check("halted", 32'(halted), 32'(m_halt));
    check("timeout", 32'(timeout), 32'(m_err));
  endtask

  task automatic do_reset();
    rd = 1'b0; wr = 1'b0; halt = 1'b0; ready = 1'b0; cond = '0;
    rst_n = 1'b0;
    #2;
    check("rst_csar", 32'(csar), 32'd0);
    check("rst_csai", 32'(csai), 32'd1);
    check("rst_memreq", 32'(memreq), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    exp_csar = 0; m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned hold_addr;
    #3;
    do_reset();

    // Sequential fetch: three clocks with NextAddr = CSAI.
    for (int i = 0; i < 3; i++) begin
      next_addr = AW'(exp_csar + 1);
      step();
    end
    check("seq_csar3", 32'(csar), 32'd3);

    // Conditional branch on n.
    cond = 3'b001; flags = 4'b0000; next_addr = AW'(exp_csar + 1);
    step();
    flags = 4'b1000; next_addr = 11'h040;
    #2 check("branch_sel_taken", 32'(sel), 32'd1);
    step();
    check("branch_csar", 32'(csar), 32'h040);

    // Decode dispatch.
    cond = 3'b111; next_addr = 11'h500;
    #2 check("decode_sel", 32'(sel), 32'd2);
    step();
    check("decode_csar", 32'(csar), 32'h500);

    // CSAI wraps at all-ones.
    cond = 3'b110; next_addr = 11'h7FF;
    step();
    check("csai_wrap", 32'(csai), 32'd0);

    // Memory read with three wait cycles.
    cond = 3'b000; rd = 1'b1; ready = 1'b0; next_addr = 11'h123;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_csar_held", 32'(csar), 32'h7FF);
    end
    ready = 1'b1;
    step();
    check("mem_done_csar", 32'(csar), 32'h123);
    rd = 1'b0; ready = 1'b0;

    // Write with zero wait.
    wr = 1'b1; ready = 1'b1; next_addr = 11'h2AA;
    step();
    wr = 1'b0; ready = 1'b0;

    // Halt request during WAIT is deferred until the access completes.
    rd = 1'b1; halt = 1'b1; next_addr = 11'h0F0;
    step();
    step();
    check("halt_deferred", 32'(halted), 32'd0);
    ready = 1'b1;
    step();
    rd = 1'b0; ready = 1'b0; next_addr = 11'h333;
    step();
    check("halt_entered", 32'(halted), 32'd1);
    hold_addr = exp_csar;
    step();
    halt = 1'b0; next_addr = 11'h444;
    step();
    check("halt_release_csar", 32'(csar), hold_addr);
    check("halt_released", 32'(halted), 32'd0);
    step();

    // Reset in the middle of WAIT.
    rd = 1'b1; ready = 1'b0;
    step();
    do_reset();

`ifdef CS_MICROSEQUENCER_TIMEOUT_EN
    rd = 1'b1; ready = 1'b0;
    for (int i = 0; i < 1 + TO; i++) step();
    check("timeout_set", 32'(timeout), 32'd1);
    #2 check("timeout_memreq", 32'(memreq), 32'd0);
    ready = 1'b1;
    step();
    step();
    do_reset();
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cond      = 3'($urandom_range(0, 7));
      flags     = 4'($urandom);
      ir13      = 1'($urandom);
      next_addr = AW'($urandom);
      rd        = ($urandom_range(0, 3) == 0);
      wr        = ($urandom_range(0, 5) == 0);
      ready     = 1'($urandom);
      halt      = ($urandom_range(0, 4) == 0);
      step();
      if (m_err) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cs_microsequencer.md
# cs_microsequencer

Microsequencer for the control section: each cycle it drives the 2-bit selection of the control store address mux from the MIR COND field and the PSR flags, registers the chosen next address into the Control Store Address Register (CSAR), and presents CSAR+1 back to the mux as CSAI. It also freezes microcode on main-memory accesses until the memory handshake completes, and supports an external halt request.

## Interface
Parameters:
- ADDR_LENGTH, 11, control store address width
- SELECTION_LENGTH, 2, mux selection width
- TIMEOUT_CYCLES, 255, wait cycles before memory timeout (1..255)

Ports:
- CS_MICROSEQUENCER_CLOCK_50  in  1  system clock, rising edge
- CS_MICROSEQUENCER_RESET_InLow  in  1  reset, asynchronous, active-low
- CS_MICROSEQUENCER_COND_InBUS  in  3  MIR COND field
- CS_MICROSEQUENCER_RD_In  in  1  MIR memory read
- CS_MICROSEQUENCER_WR_In  in  1  MIR memory write
- CS_MICROSEQUENCER_MemReady_In  in  1  memory done, valid while MemReq_Out=1
- CS_MICROSEQUENCER_Flags_InBUS  in  4  PSR {n,z,v,c}, bit 3 = n
- CS_MICROSEQUENCER_IR13_In  in  1  IR bit 13
- CS_MICROSEQUENCER_HaltReq_In  in  1  halt request, level
- CS_MICROSEQUENCER_NextAddr_InBUS  in  ADDR_LENGTH  address mux output
- CS_MICROSEQUENCER_selection_OutBUS  out  SELECTION_LENGTH  mux selection (00 CSAI, 01 MIR, 10 decode)
- CS_MICROSEQUENCER_CSAR_OutBUS  out  ADDR_LENGTH  registered control store address
- CS_MICROSEQUENCER_CSAI_OutBUS  out  ADDR_LENGTH  CSAR+1
- CS_MICROSEQUENCER_MemReq_Out  out  1  memory access in progress
- CS_MICROSEQUENCER_Stall_Out  out  1  CSAR/MIR hold
- CS_MICROSEQUENCER_Halted_Out  out  1  in HALT
- CS_MICROSEQUENCER_Timeout_Out  out  1  sticky memory timeout

## Operation
- States: RUN, WAIT, HALT, ERROR. Reset enters RUN.
- Selection (combinational, all states, from COND): 000 -> 00; 001/010/011/100 -> 01 if n/z/v/c = 1, else 00; 101 -> 01 if IR13 = 1, else 00; 110 -> 01; 111 -> 10.
- CSAI = CSAR + 1, modulo 2^ADDR_LENGTH (all-ones wraps to 0).
- RUN, RD=WR=0, HaltReq=0: CSAR <= NextAddr; stay RUN.
- RUN, RD or WR = 1: MemReq_Out=1 combinationally. If MemReady=1 in the same cycle, CSAR <= NextAddr, stay RUN (zero-wait). Otherwise hold CSAR, go WAIT, clear wait counter.
- WAIT: MemReq_Out=1, Stall_Out=1, CSAR held. If MemReady=1, CSAR <= NextAddr, go RUN. Otherwise the counter increments.
- RUN, HaltReq=1, no memory op: hold CSAR, go HALT. In HALT, Halted_Out=1, Stall_Out=1, and CSAR is held. HaltReq=0 returns to RUN with no CSAR update on that edge.
- HaltReq during WAIT or a memory op is deferred until the access completes. A memory op takes priority over a halt in the same cycle.
- RD and WR both 1: treated as a single access.
- Stall_Out = 1 whenever CSAR does not load on the next edge (WAIT without MemReady, RUN with an unfinished memory op, HALT, ERROR).

## Timing
- Reset values (asynchronous): CSAR=0, state RUN, counter 0, Timeout_Out=0. Outputs after reset: selection per COND, CSAI=1, MemReq=0 (unless RD/WR), Halted_Out=0.
- Reset mid-WAIT or mid-HALT aborts immediately; MemReq_Out drops with the reset assertion.
- Branch latency: one cycle. A COND evaluated in cycle k appears on CSAR after edge k+1.
- Flags and IR13 are sampled on the loading edge; in WAIT, the values at the completing edge are used.
- A memory access with N wait cycles stalls CSAR for N cycles.

## Configuration
- CS_MICROSEQUENCER_TIMEOUT_EN defined: in WAIT, if the counter reaches TIMEOUT_CYCLES with MemReady=0, go ERROR. ERROR sets Timeout_Out=1, MemReq=0, Stall_Out=1, holds CSAR, and is left only by reset. MemReady=1 on the terminal-count cycle completes normally.
- Not defined: no counter; WAIT lasts indefinitely; Timeout_Out is tied 0; the ERROR state does not exist.

## Test plan
- Reset with COND=000 -> CSAR=0, CSAI=1; three clocks, NextAddr fed from CSAI -> CSAR=3.
- COND=001, Flags=4'b0000 then 4'b1000, MIR address 11'h40 -> selection 00 then 01; CSAR=11'h40 after second edge.
- COND=111 -> selection 10; NextAddr 11'h500 -> CSAR=11'h500 after one edge.
- RD=1, MemReady low 3 cycles then high -> MemReq high 4 cycles, Stall 3 cycles, CSAR updates on the 4th edge.
- HaltReq=1 during WAIT -> HALT entered only after MemReady; HaltReq=0 -> RUN, CSAR unchanged on release edge.
- TIMEOUT_EN, TIMEOUT_CYCLES=4, MemReady held low -> Timeout_Out=1 after 4 WAIT cycles, MemReq=0; cleared only by RESET_InLow=0.
